// File: rtl/mem_arb_pkg.sv
// Shared types for the IFU/LSU memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
    typedef enum logic {OWN_IFU, OWN_LSU} owner_e;

    // Counter width able to hold 0..n; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between IFU and LSU: LSU priority, IFU forced after a streak of contested LSU wins.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int LSU_STREAK_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic ifu_valid_i,
    input  logic lsu_valid_i,
    output logic ifu_gnt_o,
    output logic lsu_gnt_o
);

    localparam int SW = cnt_w(LSU_STREAK_MAX);
    localparam logic [SW-1:0] SMAX = SW'(LSU_STREAK_MAX);

    logic [SW-1:0] streak_q, streak_d;
    logic          force_ifu;

    always_comb begin
        force_ifu = ifu_valid_i && (streak_q == SMAX);
        lsu_gnt_o = en_i && lsu_valid_i && !force_ifu;
        ifu_gnt_o = en_i && ifu_valid_i && !lsu_gnt_o;
        streak_d  = streak_q;
        // Only contested LSU wins count towards IFU starvation.
        if (ifu_gnt_o)
            streak_d = '0;
        else if (lsu_gnt_o && ifu_valid_i && (streak_q != SMAX))
            streak_d = streak_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) streak_q <= '0;
        else       streak_q <= streak_d;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding memory port shared by IFU (read) and LSU (read/write), with response timeout.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int LSU_STREAK_MAX = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_rsp_valid,
    output logic [DATA_W-1:0]   ifu_rsp_rdata,
    output logic                ifu_rsp_err,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic                lsu_we,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    output logic                lsu_rsp_valid,
    output logic [DATA_W-1:0]   lsu_rsp_rdata,
    output logic                lsu_rsp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_rdata,
    output logic                busy
);

    localparam int TW = cnt_w(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_e              state_q, state_d;
    owner_e              owner_q;
    logic                we_q, err_q, stale_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q, rdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic [TW-1:0]       tmo_q;
    logic                ifu_gnt, lsu_gnt, grant_en, tmo_hit;

    // rst_n is active-high; gating here keeps req_ready low while reset is held.
    assign grant_en = (state_q == IDLE) && !stale_q && !rst_n;
    assign tmo_hit  = (TIMEOUT_CYCLES != 0) && (tmo_q == TMO_LAST);

    mem_arb_pick #(.LSU_STREAK_MAX(LSU_STREAK_MAX)) u_pick (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (grant_en),
        .ifu_valid_i (ifu_req_valid),
        .lsu_valid_i (lsu_req_valid),
        .ifu_gnt_o   (ifu_gnt),
        .lsu_gnt_o   (lsu_gnt)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ifu_gnt || lsu_gnt) state_d = ISSUE;
            ISSUE:   if (mem_req_ready) state_d = WAIT;
            WAIT:    if (mem_rsp_valid || tmo_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= IDLE;
            owner_q <= OWN_IFU;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            stale_q <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            if (ifu_gnt || lsu_gnt) begin
                owner_q <= lsu_gnt ? OWN_LSU : OWN_IFU;
                we_q    <= lsu_gnt && lsu_we;
                addr_q  <= lsu_gnt ? lsu_addr : ifu_addr;
                wdata_q <= lsu_gnt ? lsu_wdata : '0;
                wstrb_q <= lsu_gnt ? lsu_wstrb : '0;
            end
            if (state_q == ISSUE) tmo_q <= '0;
            if (state_q == WAIT) begin
                if (mem_rsp_valid) begin
                    rdata_q <= we_q ? '0 : mem_rsp_rdata;
                    err_q   <= 1'b0;
                end else if (tmo_hit) begin
                    // Slave still owes a beat; swallow it when it finally arrives.
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                    stale_q <= 1'b1;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
            end
            if (stale_q && mem_rsp_valid) stale_q <= 1'b0;
        end
    end

    assign ifu_req_ready = ifu_gnt;
    assign lsu_req_ready = lsu_gnt;
    assign mem_req_valid = (state_q == ISSUE);
    assign mem_we        = we_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign mem_wstrb     = wstrb_q;
    assign ifu_rsp_valid = (state_q == RESP) && (owner_q == OWN_IFU);
    assign lsu_rsp_valid = (state_q == RESP) && (owner_q == OWN_LSU);
    assign ifu_rsp_rdata = rdata_q;
    assign lsu_rsp_rdata = rdata_q;
    assign ifu_rsp_err   = ifu_rsp_valid && err_q;
    assign lsu_rsp_err   = lsu_rsp_valid && err_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, scoreboard of expected responses, and corner sequences.
module tb_mem_port_arbiter;

    localparam int AW = 32, DW = 32, TMO = 8;

    logic clk = 1'b0, rst_n = 1'b1;
    logic ifu_req_valid = 0, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
    logic [AW-1:0] ifu_addr = '0;
    logic [DW-1:0] ifu_rsp_rdata;
    logic lsu_req_valid = 0, lsu_req_ready, lsu_we = 0, lsu_rsp_valid, lsu_rsp_err;
    logic [AW-1:0] lsu_addr = '0;
    logic [DW-1:0] lsu_wdata = '0, lsu_rsp_rdata;
    logic [3:0] lsu_wstrb = '0;
    logic mem_req_valid, mem_req_ready = 0, mem_we, mem_rsp_valid = 0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rsp_rdata = '0;
    logic [3:0] mem_wstrb;
    logic busy;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LSU_STREAK_MAX(4), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_rdata(ifu_rsp_rdata), .ifu_rsp_err(ifu_rsp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_we(lsu_we),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_rdata(lsu_rsp_rdata), .lsu_rsp_err(lsu_rsp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .busy(busy)
    );

    typedef struct {
        logic lsu; logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb;
        int rdy; int rsp; logic [31:0] exp_rdata;
    } vec_t;
    typedef struct { logic lsu; logic [31:0] rdata; logic err; } rsp_t;

    rsp_t sb[$];
    logic lsu_log[$];
    int tests = 0, fails = 0, cyc = 0, due_cyc = -1, hs_cyc = 0;
    int rdy_dly = 0, rsp_dly = 2;
    bit mem_drop = 0, expect_late = 0;
    logic [31:0] last_rdata = '0;

    function automatic logic [31:0] data_for(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], 16'h5A5A};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory slave model: ready after rdy_dly cycles, response rsp_dly cycles after handshake.
    int rcnt = 0, pcnt = 0;
    bit pend = 0, pwe = 0, waiting = 0;
    logic [31:0] paddr, s_addr, s_wdata;
    logic [4:0] s_ctl;
    always @(negedge clk) begin
        mem_req_ready = 0;
        mem_rsp_valid = 0;
        mem_rsp_rdata = 32'h0BAD_0BAD;
        if (rst_n) begin
            pend = 0; waiting = 0;
        end else if (pend) begin
            if (pcnt <= 1 && !mem_drop) begin
                mem_rsp_valid = 1;
                mem_rsp_rdata = pwe ? 32'hBAD0_BAD0 : data_for(paddr);
                pend = 0;
                if (expect_late) expect_late = 0;
                else due_cyc = cyc + 1;
            end else if (pcnt > 1) pcnt--;
        end else if (mem_req_valid) begin
            if (!waiting) begin
                waiting = 1; rcnt = rdy_dly;
                s_addr = mem_addr; s_wdata = mem_wdata; s_ctl = {mem_we, mem_wstrb};
            end else begin
                chk("req_stable_data", {mem_addr, mem_wdata}, {s_addr, s_wdata});
                chk("req_stable_ctl", {mem_we, mem_wstrb}, s_ctl);
            end
            if (rcnt == 0) begin
                mem_req_ready = 1; waiting = 0; pend = 1; pcnt = rsp_dly;
                paddr = mem_addr; pwe = mem_we; hs_cyc = cyc + 1;
            end else rcnt--;
        end
    end

    // Scoreboard: push on accept, pop and compare on response pulse.
    always @(negedge clk) begin
        rsp_t r;
        #2;
        if (!rst_n) begin
            if (ifu_req_valid && lsu_req_valid)
                chk("one_ready", {ifu_req_ready, lsu_req_ready} == 2'b11, 1'b0);
            if (lsu_req_valid && lsu_req_ready) begin
                sb.push_back('{1'b1, (mem_drop || lsu_we) ? 32'h0 : data_for(lsu_addr), mem_drop});
                lsu_log.push_back(1'b1);
            end else if (ifu_req_valid && ifu_req_ready) begin
                sb.push_back('{1'b0, mem_drop ? 32'h0 : data_for(ifu_addr), mem_drop});
                lsu_log.push_back(1'b0);
            end
            if (ifu_rsp_valid || lsu_rsp_valid) begin
                if (sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL rsp_unexpected: ifu=%0b lsu=%0b, required no response", ifu_rsp_valid, lsu_rsp_valid);
                end else begin
                    r = sb.pop_front();
                    chk("rsp_owner", {ifu_rsp_valid, lsu_rsp_valid}, r.lsu ? 2'b01 : 2'b10);
                    chk("rsp_rdata", r.lsu ? lsu_rsp_rdata : ifu_rsp_rdata, r.rdata);
                    chk("rsp_err", r.lsu ? lsu_rsp_err : ifu_rsp_err, r.err);
                    if (r.err) chk("tmo_latency", cyc, hs_cyc + TMO);
                    else       chk("rsp_latency", cyc, due_cyc);
                    last_rdata = r.lsu ? lsu_rsp_rdata : ifu_rsp_rdata;
                end
            end
        end
    end

    task automatic issue(input logic lsu, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] ws);
        int k;
        @(negedge clk);
        if (lsu) begin
            lsu_req_valid = 1; lsu_we = we; lsu_addr = a; lsu_wdata = wd; lsu_wstrb = ws; ifu_addr = ~a;
        end else begin
            ifu_req_valid = 1; ifu_addr = a; lsu_addr = ~a; lsu_we = 1; lsu_wstrb = '1; lsu_wdata = 32'hFFFF0000;
        end
        k = 0; #1;
        while (!(ifu_req_ready || lsu_req_ready) && k < 50) begin @(negedge clk); #1; k++; end
        if (k >= 50) begin tests++; fails++; $display("FAIL accept_timeout: no req_ready within 50 cycles"); end
        @(negedge clk);
        ifu_req_valid = 0; lsu_req_valid = 0;
        ifu_addr = 32'h5555_0000; lsu_addr = 32'h6666_0000; lsu_wdata = 32'h7777_7777; lsu_wstrb = 4'hA;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        do begin @(negedge clk); #3; k++; end while ((busy || sb.size() != 0) && k < 200);
        if (k >= 200) begin tests++; fails++; $display("FAIL idle_timeout: busy=%0b pending=%0d", busy, sb.size()); end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v[6];
        logic exp_order[10];
        int k;
        v[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, 2, 32'hDEADBEEF};
        v[1] = '{1'b1, 1'b1, 32'h0000_0200, 32'h12345678, 4'b0011, 0, 1, 32'h0};
        v[2] = '{1'b1, 1'b0, 32'h0000_0304, 32'h0, 4'h0, 1, 3, 32'h0304_5A5A};
        v[3] = '{1'b0, 1'b0, 32'h0000_1000, 32'h0, 4'h0, 10, 1, 32'h1000_5A5A};
        v[4] = '{1'b1, 1'b1, 32'h0000_ABC0, 32'hCAFEF00D, 4'b1111, 2, 1, 32'h0};
        v[5] = '{1'b0, 1'b0, 32'h0000_FFFC, 32'h0, 4'h0, 0, 1, 32'hFFFC_5A5A};
        exp_order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

        repeat (2) @(negedge clk);
        #1;
        chk("reset_ctl", {busy, mem_req_valid, ifu_rsp_valid, lsu_rsp_valid, ifu_req_ready, lsu_req_ready}, 6'b0);
        chk("reset_fields", {mem_we, mem_wstrb, mem_addr}, 37'b0);
        @(negedge clk) rst_n = 0;

        for (int i = 0; i < 6; i++) begin
            rdy_dly = v[i].rdy; rsp_dly = v[i].rsp;
            issue(v[i].lsu, v[i].we, v[i].addr, v[i].wdata, v[i].wstrb);
            #1;
            chk("vec_req_valid", mem_req_valid, 1'b1);
            chk("vec_addr", mem_addr, v[i].addr);
            chk("vec_we_strb", {mem_we, mem_wstrb}, {v[i].we, v[i].lsu ? v[i].wstrb : 4'h0});
            if (v[i].lsu) chk("vec_wdata", mem_wdata, v[i].wdata);
            wait_idle();
            chk("vec_rdata", last_rdata, v[i].exp_rdata);
        end

        // Contested arbitration from a cleared streak.
        @(negedge clk) rst_n = 1;
        @(negedge clk) rst_n = 0;
        lsu_log.delete(); rdy_dly = 0; rsp_dly = 1;
        @(negedge clk);
        ifu_req_valid = 1; lsu_req_valid = 1; lsu_we = 0; ifu_addr = 32'h500; lsu_addr = 32'h600;
        k = 0;
        while (lsu_log.size() < 10 && k < 400) begin @(negedge clk); k++; end
        ifu_req_valid = 0; lsu_req_valid = 0;
        chk("streak_count", lsu_log.size(), 10);
        for (int i = 0; i < 10 && i < lsu_log.size(); i++) chk("streak_order", lsu_log[i], exp_order[i]);
        wait_idle();

        // Timeout, stale blocking, late response discarded.
        mem_drop = 1;
        issue(1'b0, 1'b0, 32'h400, 32'h0, 4'h0);
        wait_idle();
        chk("tmo_rdata", last_rdata, 32'h0);
        @(negedge clk);
        ifu_req_valid = 1; ifu_addr = 32'h700; lsu_req_valid = 1; lsu_we = 0; lsu_addr = 32'h704;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("stale_no_grant", {ifu_req_ready, lsu_req_ready}, 2'b00);
        end
        expect_late = 1; mem_drop = 0;
        k = 0;
        do begin @(negedge clk); #1; k++; end while (!(ifu_req_ready || lsu_req_ready) && k < 20);
        chk("post_stale_grant", {ifu_req_ready, lsu_req_ready}, 2'b01);
        @(negedge clk);
        ifu_req_valid = 0; lsu_req_valid = 0;
        wait_idle();
        chk("post_stale_rdata", last_rdata, 32'h0704_5A5A);

        // Reset while waiting on memory.
        mem_drop = 1;
        issue(1'b1, 1'b0, 32'h800, 32'h0, 4'h0);
        repeat (3) @(negedge clk);
        #1;
        chk("pre_reset_busy", busy, 1'b1);
        rst_n = 1;
        #1;
        sb.delete();
        chk("midreset_ctl", {busy, mem_req_valid, ifu_rsp_valid, lsu_rsp_valid, ifu_rsp_err, lsu_rsp_err}, 6'b0);
        chk("midreset_fields", {mem_we, mem_wstrb, mem_addr}, 37'b0);
        @(negedge clk);
        @(negedge clk) rst_n = 0;
        mem_drop = 0; rsp_dly = 2;
        repeat (3) @(negedge clk);
        issue(1'b0, 1'b0, 32'h100, 32'h0, 4'h0);
        wait_idle();
        chk("after_reset_rdata", last_rdata, 32'hDEADBEEF);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
